// File: rtl/yasac_pkg.sv
// rtl/yasac_pkg.sv - shared constants and loader state encoding for the YASAC front-end
package yasac_pkg;

  localparam int BYTE_WIDTH  = 8;
  localparam int INSTR_WIDTH = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GET_OPND = 3'd1,
    ST_GET_HI   = 3'd2,
    ST_GET_LO   = 3'd3,
    ST_WRITE    = 3'd4,
    ST_ARM      = 3'd5,
    ST_RUN      = 3'd6,
    ST_DONE     = 3'd7
  } state_t;

endpackage

// File: rtl/yasac_loader_if.sv
// rtl/yasac_loader_if.sv - host byte link, program memory write port and processor control
interface yasac_loader_if
  import yasac_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) ();

  logic                   host_valid;
  logic [BYTE_WIDTH-1:0]  host_data;
  logic                   host_ready;
  logic                   pm_we;
  logic [ADDR_WIDTH-1:0]  pm_addr;
  logic [INSTR_WIDTH-1:0] pm_wdata;
  logic                   cpu_reset;
  logic                   cpu_start;
  logic [BYTE_WIDTH-1:0]  cpu_data_in;
  logic                   cpu_ready;
  logic [BYTE_WIDTH-1:0]  cpu_data_out;

  modport master (
    input  host_valid, host_data, cpu_ready, cpu_data_out,
    output host_ready, pm_we, pm_addr, pm_wdata, cpu_reset, cpu_start, cpu_data_in
  );

  modport slave (
    output host_valid, host_data, cpu_ready, cpu_data_out,
    input  host_ready, pm_we, pm_addr, pm_wdata, cpu_reset, cpu_start, cpu_data_in
  );

endinterface

// File: rtl/yasac_loader_timer.sv
// rtl/yasac_loader_timer.sv - run-cycle counter with clear, enable and limit-reached flag
module yasac_loader_timer #(
  parameter int RUN_LIMIT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic limit_hit
);

  localparam int CW = (RUN_LIMIT > 2) ? $clog2(RUN_LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(RUN_LIMIT - 1);

  logic [CW-1:0] count;

  // Saturates at LAST so the flag stays up until the next clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !limit_hit) begin
      count <= count + CW'(1);
    end
  end

  assign limit_hit = (count == LAST);

endmodule

// File: rtl/yasac_loader.sv
// rtl/yasac_loader.sv - loads a program image into YASAC memory, runs it and captures the result
module yasac_loader
  import yasac_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int RUN_LIMIT  = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  yasac_loader_if.master        bus,
  output logic [BYTE_WIDTH-1:0] result,
  output logic                  result_valid,
  output logic                  done,
  output logic                  error,
  output logic [2:0]            state_out
);

  state_t                state, state_nx;
  logic [BYTE_WIDTH-1:0] word_count, word_idx, hi_byte, lo_byte, opnd;
  logic                  arm_wait, seen_busy;
  logic                  host_ready, pm_we, cpu_reset, cpu_start;
  logic                  tmr_clear, tmr_en, limit_hit;
  logic                  last_word;

  assign last_word = (word_idx == word_count - 8'd1);

  yasac_loader_timer #(.RUN_LIMIT(RUN_LIMIT)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .clear     (tmr_clear),
    .enable    (tmr_en),
    .limit_hit (limit_hit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // The processor is held in reset for the whole load and released from ARM until DONE.
  always_comb begin
    state_nx   = state;
    host_ready = 1'b0;
    pm_we      = 1'b0;
    cpu_reset  = 1'b1;
    cpu_start  = 1'b0;
    done       = 1'b0;
    tmr_clear  = 1'b0;
    tmr_en     = 1'b0;
    case (state)
      ST_IDLE: begin
        host_ready = 1'b1;
        if (bus.host_valid && bus.host_data != '0) state_nx = ST_GET_OPND;
      end
      ST_GET_OPND: begin
        host_ready = 1'b1;
        if (bus.host_valid) state_nx = ST_GET_HI;
      end
      ST_GET_HI: begin
        host_ready = 1'b1;
        if (bus.host_valid) state_nx = ST_GET_LO;
      end
      ST_GET_LO: begin
        host_ready = 1'b1;
        if (bus.host_valid) state_nx = ST_WRITE;
      end
      ST_WRITE: begin
        pm_we    = 1'b1;
        state_nx = last_word ? ST_ARM : ST_GET_HI;
      end
      ST_ARM: begin
        cpu_reset = 1'b0;
        if (arm_wait && bus.cpu_ready) begin
          cpu_start = 1'b1;
          tmr_clear = 1'b1;
          state_nx  = ST_RUN;
        end
      end
      ST_RUN: begin
        cpu_reset = 1'b0;
        tmr_en    = 1'b1;
        if (bus.cpu_ready && seen_busy) state_nx = ST_DONE;
        else if (limit_hit)             state_nx = ST_IDLE;
      end
      ST_DONE: begin
        cpu_reset = 1'b0;
        done      = 1'b1;
        state_nx  = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_count   <= '0;
      word_idx     <= '0;
      hi_byte      <= '0;
      lo_byte      <= '0;
      opnd         <= '0;
      arm_wait     <= 1'b0;
      seen_busy    <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      error        <= 1'b0;
    end else begin
      arm_wait <= (state == ST_ARM);
      case (state)
        ST_IDLE: if (bus.host_valid) begin
          error        <= (bus.host_data == '0);
          result_valid <= 1'b0;
          word_count   <= bus.host_data;
          word_idx     <= '0;
        end
        ST_GET_OPND: if (bus.host_valid) opnd    <= bus.host_data;
        ST_GET_HI:   if (bus.host_valid) hi_byte <= bus.host_data;
        ST_GET_LO:   if (bus.host_valid) lo_byte <= bus.host_data;
        ST_WRITE:    if (!last_word) word_idx <= word_idx + 8'd1;
        ST_ARM:      if (cpu_start) seen_busy <= 1'b0;
        ST_RUN: begin
          if (!bus.cpu_ready) seen_busy <= 1'b1;
          if (!(bus.cpu_ready && seen_busy) && limit_hit) error <= 1'b1;
        end
        ST_DONE: begin
          result       <= bus.cpu_data_out;
          result_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.host_ready  = host_ready;
  assign bus.pm_we       = pm_we;
  assign bus.pm_addr     = ADDR_WIDTH'(word_idx);
  assign bus.pm_wdata    = {hi_byte, lo_byte};
  assign bus.cpu_reset   = cpu_reset;
  assign bus.cpu_start   = cpu_start;
  assign bus.cpu_data_in = opnd;
  assign state_out       = state;

endmodule

// File: tb/tb_yasac_loader.sv
// tb/tb_yasac_loader.sv - directed self-checking bench for yasac_loader
module tb_yasac_loader;
  import yasac_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       hv = 1'b0;
  logic [7:0] hd = 8'h00;
  logic       cpu_ready_m = 1'b1;
  logic [7:0] data_out_m = 8'h00;
  logic [7:0] result;
  logic       result_valid, done, error;
  logic [2:0] state_out;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0, start_cnt = 0, done_cnt = 0;
  logic [7:0]  wr_addr [0:7];
  logic [15:0] wr_data [0:7];
  logic [15:0] words [0:3];
  int          mode = 0;
  logic [7:0]  model_data = 8'h2A;
  int          busy = 0;

  always #5 clk = ~clk;

  yasac_loader_if #(.ADDR_WIDTH(8)) bus ();

  assign bus.host_valid   = hv;
  assign bus.host_data    = hd;
  assign bus.cpu_ready    = cpu_ready_m;
  assign bus.cpu_data_out = data_out_m;

  yasac_loader #(.ADDR_WIDTH(8), .RUN_LIMIT(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .result       (result),
    .result_valid (result_valid),
    .done         (done),
    .error        (error),
    .state_out    (state_out)
  );

  // Processor model: mode 0 drops ready for 5 cycles after start, mode 1 never leaves ready.
  always @(posedge clk) begin
    if (bus.cpu_reset) begin
      cpu_ready_m <= 1'b1;
      busy        <= 0;
    end else if (mode == 1) begin
      data_out_m <= 8'h99;
    end else if (bus.cpu_start) begin
      cpu_ready_m <= 1'b0;
      busy        <= 4;
    end else if (busy != 0) begin
      busy <= busy - 1;
    end else if (!cpu_ready_m) begin
      cpu_ready_m <= 1'b1;
      data_out_m  <= model_data;
    end
  end

  always @(negedge clk) begin
    if (bus.pm_we === 1'b1) begin
      if (wr_cnt < 8) begin
        wr_addr[wr_cnt] = bus.pm_addr;
        wr_data[wr_cnt] = bus.pm_wdata;
      end
      wr_cnt++;
    end
    if (bus.cpu_start === 1'b1) start_cnt++;
    if (done === 1'b1) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    hv = 1'b1;
    hd = b;
    while (bus.host_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_bound", 32'(n < 50), 32'd1);
    @(negedge clk);
  endtask

  task automatic load(input logic [7:0] n, input logic [7:0] op);
    send_byte(n);
    send_byte(op);
    for (int i = 0; i < int'(n); i++) begin
      send_byte(words[i][15:8]);
      send_byte(words[i][7:0]);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < 100);
    chk("done_seen", 32'(done), 32'd1);
    chk("done_state", 32'(state_out), 32'd7);
    @(negedge clk);
  endtask

  task automatic clear_counts();
    wr_cnt = 0;
    start_cnt = 0;
    done_cnt = 0;
  endtask

  initial begin
    int n;
    #1 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_state", 32'(state_out), 32'd0);
    chk("rst_pm_we", 32'(bus.pm_we), 32'd0);
    chk("rst_pm_addr", 32'(bus.pm_addr), 32'd0);
    chk("rst_pm_wdata", 32'(bus.pm_wdata), 32'd0);
    chk("rst_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    chk("rst_cpu_start", 32'(bus.cpu_start), 32'd0);
    chk("rst_cpu_data_in", 32'(bus.cpu_data_in), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_result_valid", 32'(result_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    reset = 1'b0;
    clear_counts();

    // Two-word load with a processor that goes busy for 5 cycles
    words[0] = 16'h1234;
    words[1] = 16'hABCD;
    load(8'd2, 8'h05);
    chk("s1_write_state", 32'(state_out), 32'd4);
    chk("s1_write_we", 32'(bus.pm_we), 32'd1);
    chk("s1_write_addr", 32'(bus.pm_addr), 32'd1);
    chk("s1_write_data", 32'(bus.pm_wdata), 32'hABCD);
    chk("s1_write_ready", 32'(bus.host_ready), 32'd0);
    hv = 1'b0;
    @(negedge clk);
    chk("s1_arm_state", 32'(state_out), 32'd5);
    chk("s1_arm_cpu_reset", 32'(bus.cpu_reset), 32'd0);
    chk("s1_arm_no_start", 32'(bus.cpu_start), 32'd0);
    @(negedge clk);
    chk("s1_arm_start", 32'(bus.cpu_start), 32'd1);
    wait_done();
    chk("s1_result", 32'(result), 32'h2A);
    chk("s1_result_valid", 32'(result_valid), 32'd1);
    chk("s1_cpu_reset_after", 32'(bus.cpu_reset), 32'd1);
    chk("s1_idle", 32'(state_out), 32'd0);
    chk("s1_done_low", 32'(done), 32'd0);
    @(negedge clk);
    chk("s1_wr_cnt", 32'(wr_cnt), 32'd2);
    chk("s1_addr0", 32'(wr_addr[0]), 32'd0);
    chk("s1_data0", 32'(wr_data[0]), 32'h1234);
    chk("s1_addr1", 32'(wr_addr[1]), 32'd1);
    chk("s1_data1", 32'(wr_data[1]), 32'hABCD);
    chk("s1_cpu_data_in", 32'(bus.cpu_data_in), 32'h05);
    chk("s1_start_cnt", 32'(start_cnt), 32'd1);
    chk("s1_done_cnt", 32'(done_cnt), 32'd1);

    // Zero word count
    clear_counts();
    send_byte(8'h00);
    hv = 1'b0;
    chk("s2_error", 32'(error), 32'd1);
    chk("s2_state", 32'(state_out), 32'd0);
    repeat (3) @(negedge clk);
    chk("s2_state_hold", 32'(state_out), 32'd0);
    chk("s2_no_write", 32'(wr_cnt), 32'd0);
    chk("s2_no_start", 32'(start_cnt), 32'd0);
    chk("s2_error_hold", 32'(error), 32'd1);

    // Next load clears error; processor never goes busy so the run times out
    mode = 1;
    send_byte(8'd1);
    chk("s3_error_cleared", 32'(error), 32'd0);
    chk("s3_rv_cleared", 32'(result_valid), 32'd0);
    chk("s3_state_opnd", 32'(state_out), 32'd1);
    send_byte(8'h77);
    send_byte(8'h0F);
    send_byte(8'h0F);
    hv = 1'b0;
    n = 0;
    while (state_out !== 3'd6 && n < 50) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (state_out === 3'd6 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("s3_run_cycles", 32'(n), 32'd8);
    chk("s3_state_idle", 32'(state_out), 32'd0);
    chk("s3_error", 32'(error), 32'd1);
    chk("s3_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    chk("s3_result_valid", 32'(result_valid), 32'd0);
    chk("s3_result_kept", 32'(result), 32'h2A);
    chk("s3_no_done", 32'(done_cnt), 32'd0);
    mode = 0;

    // Three words with host_valid held high through every WRITE cycle
    clear_counts();
    model_data = 8'h5A;
    words[0] = 16'h0102;
    words[1] = 16'h0304;
    words[2] = 16'h0506;
    load(8'd3, 8'h11);
    hv = 1'b0;
    wait_done();
    chk("s4_result", 32'(result), 32'h5A);
    chk("s4_error", 32'(error), 32'd0);
    chk("s4_wr_cnt", 32'(wr_cnt), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("s4_addr", 32'(wr_addr[i]), 32'(i));
      chk("s4_data", 32'(wr_data[i]), 32'(words[i]));
    end
    chk("s4_cpu_data_in", 32'(bus.cpu_data_in), 32'h11);
    chk("s4_start_cnt", 32'(start_cnt), 32'd1);

    // Asynchronous reset while the low byte of word 1 is pending
    clear_counts();
    model_data = 8'h2A;
    send_byte(8'd2);
    send_byte(8'h42);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'hAB);
    hd = 8'hCD;
    chk("s5_state_lo", 32'(state_out), 32'd3);
    #2 reset = 1'b1;
    #1;
    chk("s5_state", 32'(state_out), 32'd0);
    chk("s5_pm_we", 32'(bus.pm_we), 32'd0);
    chk("s5_pm_addr", 32'(bus.pm_addr), 32'd0);
    chk("s5_pm_wdata", 32'(bus.pm_wdata), 32'd0);
    chk("s5_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    chk("s5_cpu_data_in", 32'(bus.cpu_data_in), 32'd0);
    chk("s5_result", 32'(result), 32'd0);
    chk("s5_result_valid", 32'(result_valid), 32'd0);
    repeat (2) @(negedge clk);
    chk("s5_wr_cnt", 32'(wr_cnt), 32'd1);
    hv = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    clear_counts();
    words[0] = 16'h1234;
    words[1] = 16'hABCD;
    load(8'd2, 8'h05);
    hv = 1'b0;
    wait_done();
    chk("s6_result", 32'(result), 32'h2A);
    chk("s6_result_valid", 32'(result_valid), 32'd1);
    chk("s6_wr_cnt", 32'(wr_cnt), 32'd2);
    chk("s6_data0", 32'(wr_data[0]), 32'h1234);
    chk("s6_addr1", 32'(wr_addr[1]), 32'd1);
    chk("s6_data1", 32'(wr_data[1]), 32'hABCD);
    chk("s6_cpu_data_in", 32'(bus.cpu_data_in), 32'h05);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/yasac_loader.md
Name: yasac_loader

Overview:
Host-side front-end that sits directly upstream of the YASAC processor. It receives a program image and an operand over a byte-wide valid/ready link and writes 16-bit instruction words into program memory. It then releases the processor from reset, pulses start, and captures data_out once the processor reports ready again. It drives the processor's reset, start and data_in, and consumes its ready and data_out.

Parameters:
ADDR_WIDTH, 8, program memory address width; must be >= 8 so that 255 words fit.
INSTR_WIDTH, 16, instruction word width; fixed at two bytes, high byte first.
RUN_LIMIT, 1024, maximum RUN-state cycles before a timeout is declared; must be >= 2.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
host_valid  in  1  host byte valid
host_data  in  8  host byte
host_ready  out  1  loader accepts a byte this cycle
pm_we  out  1  program memory write strobe, one cycle per word
pm_addr  out  ADDR_WIDTH  program memory write address
pm_wdata  out  INSTR_WIDTH  program memory write data
cpu_reset  out  1  processor reset (processor reset is synchronous, active-high)
cpu_start  out  1  processor START, one-cycle pulse
cpu_data_in  out  8  operand presented on processor data_in
cpu_ready  in  1  processor READY
cpu_data_out  in  8  processor data_out
result  out  8  captured processor result
result_valid  out  1  result holds a completed run
done  out  1  one-cycle pulse on completion
error  out  1  sticky; set by a zero count or a timeout
state_out  out  3  FSM state encoding

Behaviour:
- Reset (asynchronous, active-high) forces the following:
  - state IDLE; pm_we=0, pm_addr=0, pm_wdata=0;
  - cpu_reset=1, cpu_start=0, cpu_data_in=0;
  - result=0, result_valid=0, done=0, error=0; word count and run counter = 0.
- Reset mid-operation aborts any load or run immediately, with no partial writes after assertion.
- host_ready=1 only in IDLE, GET_OPND, GET_HI and GET_LO. A byte is accepted when host_valid && host_ready.
- State encoding: IDLE=0, GET_OPND=1, GET_HI=2, GET_LO=3, WRITE=4, ARM=5, RUN=6, DONE=7.
- IDLE:
  - cpu_reset=1.
  - An accepted byte is the word count N; it clears error and result_valid.
  - N=0: set error, stay in IDLE.
  - Otherwise latch N, set word index to 0, go to GET_OPND.
- GET_OPND: accepted byte goes to cpu_data_in (held until the next load); go to GET_HI.
- GET_HI: latch the high byte; go to GET_LO.
- GET_LO: latch the low byte; go to WRITE.
- WRITE (exactly one cycle):
  - pm_we=1, pm_addr=word index, pm_wdata={hi,lo}; host_ready=0.
  - If index==N-1, go to ARM; else increment the index and go to GET_HI.
- ARM:
  - cpu_reset=0 from ARM entry onward.
  - Wait at least one cycle, then until cpu_ready==1.
  - Then drive cpu_start=1 for exactly one cycle, clear the run counter, clear seen_busy, go to RUN.
- RUN:
  - Run counter increments every cycle.
  - cpu_ready==0 sets seen_busy.
  - cpu_ready==1 with seen_busy set goes to DONE.
  - If the counter reaches RUN_LIMIT-1 first: set error, assert cpu_reset, go to IDLE. No result is captured.
  - Completion and limit in the same cycle: completion wins.
- DONE (one cycle):
  - result<=cpu_data_out, result_valid<=1, done=1.
  - Go to IDLE, which re-asserts cpu_reset the following cycle.
- host_valid held high while host_ready=0 is ignored; the byte stays pending, nothing is dropped.
- Maximum program is N=255 words. pm_addr is zero-extended when ADDR_WIDTH>8.
- Latency: the last low byte is accepted at cycle t, so pm_we occurs at t+1 and ARM starts at t+2.

Decomposition:
- Shared package yasac_pkg holds:
  - loader state constants (3-bit encoding above);
  - INSTR_WIDTH;
  - byte width 8.
- One natural sub-module: yasac_loader_timer, a run counter with clear, enable and a limit-reached flag, parameterised by RUN_LIMIT.
- The host-byte FSM and word assembly stay in yasac_loader.

Test Plan:
- Load N=2, operand 0x05, words 0x1234, 0xABCD:
  - pm_we is pulsed twice, with (addr 0, 0x1234) and (addr 1, 0xABCD);
  - cpu_data_in=0x05; one cpu_start pulse in ARM.
- Behavioural CPU model that drops ready for 5 cycles and returns data_out=0x2A:
  - done pulses once; result=0x2A; result_valid=1; cpu_reset=1 the cycle after DONE.
- Count byte 0x00:
  - error=1, state stays IDLE, no pm_we, cpu_start never asserted.
  - The next valid load clears error.
- CPU model that keeps ready=1 after start, with RUN_LIMIT=8:
  - after 8 RUN cycles error=1, cpu_reset=1, state IDLE, result_valid=0.
- host_valid held high continuously across WRITE cycles, N=3:
  - exactly 3 writes with correct addresses 0..2 and no byte lost or duplicated.
- Assert reset during GET_LO of word 1:
  - all outputs return to their reset values asynchronously; no further pm_we;
  - a subsequent full load behaves as in scenario 1.
